// File: rtl/im_lut_loader.sv
// Boot-time fill engine for the immediate lookup table used by LOAD_IMM.
// It takes DATA_PATH_WIDTH-bit words over a valid/ready stream and writes them
// to LUT indices 0..LUT_SIZE-1 in order, one cycle after each accepted word.
// Optional feature macro: IM_LUT_LOADER_CHECKSUM_EN. When it is defined, one
// extra stream word after the last entry is compared against the modular sum
// of all entries. A mismatch raises o_err.
module im_lut_loader #(
  parameter int unsigned DATA_PATH_WIDTH = 8,
  parameter int unsigned LUT_SIZE        = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic                       i_in_valid,
  input  logic [DATA_PATH_WIDTH-1:0] i_in_data,
  output logic                       o_in_ready,
  output logic                       o_lut_wr_en,
  output logic [4:0]                 o_lut_wr_addr,
  output logic [DATA_PATH_WIDTH-1:0] o_lut_wr_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err
);

  localparam logic [4:0] LastIdx = 5'(LUT_SIZE - 1);

`ifdef IM_LUT_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;
`endif

  state_e                     r_state, w_state_nxt;
  logic [4:0]                 r_count, w_count_nxt;
  logic                       r_wr_en, w_wr_en_nxt;
  logic [4:0]                 r_wr_addr, w_wr_addr_nxt;
  logic [DATA_PATH_WIDTH-1:0] r_wr_data, w_wr_data_nxt;
  logic                       w_hs;
`ifdef IM_LUT_LOADER_CHECKSUM_EN
  logic                       r_err, w_err_nxt;
  logic [DATA_PATH_WIDTH-1:0] r_sum, w_sum_nxt;
`endif

  // Ready is purely a function of state so upstream sees it without a bubble.
`ifdef IM_LUT_LOADER_CHECKSUM_EN
  assign o_in_ready = (r_state == StLoad) || (r_state == StCheck);
`else
  assign o_in_ready = (r_state == StLoad);
`endif
  assign w_hs = i_in_valid & o_in_ready;

  // State register and registered write port; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
`ifdef IM_LUT_LOADER_CHECKSUM_EN
      r_err     <= 1'b0;
      r_sum     <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
`ifdef IM_LUT_LOADER_CHECKSUM_EN
      r_err     <= w_err_nxt;
      r_sum     <= w_sum_nxt;
`endif
    end
  end

  // Next-state, datapath updates and state-decoded status outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
`ifdef IM_LUT_LOADER_CHECKSUM_EN
    w_err_nxt     = r_err;
    w_sum_nxt     = r_sum;
`endif
    o_busy        = 1'b0;
    o_done        = 1'b0;
    case (r_state)
      StIdle, StDone: begin
        o_done = (r_state == StDone);
        if (i_start) begin
          w_state_nxt = StLoad;
          w_count_nxt = '0;
`ifdef IM_LUT_LOADER_CHECKSUM_EN
          w_err_nxt   = 1'b0;
          w_sum_nxt   = '0;
`endif
        end
      end
      StLoad: begin
        o_busy = 1'b1;
        if (w_hs) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_count;
          w_wr_data_nxt = i_in_data;
`ifdef IM_LUT_LOADER_CHECKSUM_EN
          w_sum_nxt     = r_sum + i_in_data;
`endif
          // Count holds at the last index so it never wraps inside a fill.
          if (r_count == LastIdx) begin
`ifdef IM_LUT_LOADER_CHECKSUM_EN
            w_state_nxt = StCheck;
`else
            w_state_nxt = StDone;
`endif
          end else begin
            w_count_nxt = r_count + 5'd1;
          end
        end
      end
`ifdef IM_LUT_LOADER_CHECKSUM_EN
      StCheck: begin
        o_busy = 1'b1;
        // The checksum word is consumed but never written to the table.
        if (w_hs) begin
          w_err_nxt   = (i_in_data != r_sum);
          w_state_nxt = StDone;
        end
      end
`endif
      default: w_state_nxt = StIdle;
    endcase
  end

  assign o_lut_wr_en   = r_wr_en;
  assign o_lut_wr_addr = r_wr_addr;
  assign o_lut_wr_data = r_wr_data;
`ifdef IM_LUT_LOADER_CHECKSUM_EN
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_im_lut_loader.sv
// Directed self-checking bench for im_lut_loader. Checksum tests are compiled
// in only when IM_LUT_LOADER_CHECKSUM_EN is defined.
module tb_im_lut_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_in_valid = 1'b0;
  logic [7:0] i_in_data = 8'h00;
  logic       o_in_ready, o_lut_wr_en, o_busy, o_done, o_err;
  logic [4:0] o_lut_wr_addr;
  logic [7:0] o_lut_wr_data;

  im_lut_loader #(
    .DATA_PATH_WIDTH(8),
    .LUT_SIZE       (32)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_in_valid   (i_in_valid),
    .i_in_data    (i_in_data),
    .o_in_ready   (o_in_ready),
    .o_lut_wr_en  (o_lut_wr_en),
    .o_lut_wr_addr(o_lut_wr_addr),
    .o_lut_wr_data(o_lut_wr_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write log, filled only by this monitor; tests snapshot a base index.
  int         cyc = 0;
  int         log_n = 0;
  logic [4:0] log_addr[512];
  logic [7:0] log_data[512];
  int         log_cyc[512];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_lut_wr_en) begin
      if (log_n < 512) begin
        log_addr[log_n] = o_lut_wr_addr;
        log_data[log_n] = o_lut_wr_data;
        log_cyc[log_n]  = cyc;
      end
      log_n = log_n + 1;
    end
  end

  logic [7:0] tb_sum = 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic begin_fill();
    tb_sum = 8'h00;
    pulse_start();
  endtask

  // Offer one word and return #1 after the edge that accepts it.
  task automatic push(input logic [7:0] d);
    i_in_valid = 1'b1;
    i_in_data  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_in_ready) begin
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        tb_sum     = tb_sum + d;
        return;
      end
    end
    i_in_valid = 1'b0;
    n_chk++;
    n_err++;
    $display("FAIL push_timeout: got no handshake expected handshake for data 0x%0h", d);
  endtask

  // With the checksum feature the fill needs the correct sum word to finish.
  task automatic finish_fill();
`ifdef IM_LUT_LOADER_CHECKSUM_EN
    push(tb_sum);
`endif
  endtask

  // Exactly 32 logged writes since base, addr i, data i (or a constant).
  task automatic check_log(input string tag, input int base, input bit use_c,
                           input logic [7:0] cval);
    int bad;
    logic [7:0] exp_d;
    bad = 0;
    check_eq({tag, "_count"}, 32'(log_n - base), 32'd32);
    for (int i = 0; i < 32; i++) begin
      exp_d = use_c ? cval : 8'(i);
      if (base + i < log_n && base + i < 512) begin
        if (log_addr[base + i] !== 5'(i) || log_data[base + i] !== exp_d) bad++;
      end else begin
        bad++;
      end
    end
    check_eq({tag, "_order"}, 32'(bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset values.
    tick();
    tick();
    check_eq("rst_in_ready", 32'(o_in_ready), 32'd0);
    check_eq("rst_wr_en", 32'(o_lut_wr_en), 32'd0);
    check_eq("rst_wr_addr", 32'(o_lut_wr_addr), 32'd0);
    check_eq("rst_wr_data", 32'(o_lut_wr_data), 32'd0);
    check_eq("rst_busy_done_err", 32'({o_busy, o_done, o_err}), 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_in_ready", 32'(o_in_ready), 32'd0);

    // Back-to-back stream 0x00..0x1F.
    base = log_n;
    begin_fill();
    check_eq("load_busy", 32'(o_busy), 32'd1);
    check_eq("load_in_ready", 32'(o_in_ready), 32'd1);
    for (int k = 0; k < 32; k++) begin
      push(8'(k));
      if (k == 0) begin
        check_eq("first_wr_lat", 32'(o_lut_wr_en), 32'd1);
        check_eq("first_wr_addr", 32'(o_lut_wr_addr), 32'd0);
      end
    end
`ifndef IM_LUT_LOADER_CHECKSUM_EN
    check_eq("last_wr_in_done", 32'({o_lut_wr_en, o_done, o_lut_wr_addr}), 32'h7F);
`endif
    finish_fill();
    tick();
    check_eq("stream_done", 32'(o_done), 32'd1);
    check_eq("stream_busy", 32'(o_busy), 32'd0);
    check_eq("stream_err", 32'(o_err), 32'd0);
    check_eq("stream_wr_en_low", 32'(o_lut_wr_en), 32'd0);
    check_log("stream", base, 1'b0, 8'h00);
    check_eq("stream_consecutive", 32'(log_cyc[base + 31] - log_cyc[base]), 32'd31);

    // Toggling valid; restart from DONE.
    base = log_n;
    begin_fill();
    check_eq("restart_done_drop", 32'(o_done), 32'd0);
    for (int k = 0; k < 32; k++) begin
      push(8'(k));
      tick();
    end
    finish_fill();
    tick();
    check_log("toggle", base, 1'b0, 8'h00);
    check_eq("toggle_spacing", 32'(log_cyc[base + 31] - log_cyc[base]), 32'd62);
    check_eq("toggle_done", 32'(o_done), 32'd1);

    // Reset after 10 accepted words.
    base = log_n;
    begin_fill();
    for (int k = 0; k < 10; k++) push(8'(k));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("midrst_outputs",
             32'({o_in_ready, o_lut_wr_en, o_lut_wr_addr, o_lut_wr_data, o_busy, o_done, o_err}),
             32'd0);
    i_in_valid = 1'b1;
    i_in_data  = 8'hAA;
    tick();
    tick();
    tick();
    check_eq("midrst_no_ready", 32'(o_in_ready), 32'd0);
    i_in_valid = 1'b0;
    tick();
    check_eq("midrst_writes", 32'(log_n - base), 32'd10);
    check_eq("midrst_done", 32'(o_done), 32'd0);
    base = log_n;
    begin_fill();
    for (int k = 0; k < 32; k++) push(8'(k));
    finish_fill();
    tick();
    check_log("refill", base, 1'b0, 8'h00);
    check_eq("refill_done", 32'(o_done), 32'd1);

    // Start pulsed mid-load at count=5 is ignored.
    base = log_n;
    begin_fill();
    for (int k = 0; k < 5; k++) push(8'(k));
    pulse_start();
    check_eq("midstart_busy", 32'(o_busy), 32'd1);
    for (int k = 5; k < 32; k++) push(8'(k));
    finish_fill();
    tick();
    check_log("midstart", base, 1'b0, 8'h00);
    check_eq("midstart_done", 32'(o_done), 32'd1);

`ifndef IM_LUT_LOADER_CHECKSUM_EN
    // Extra word after DONE is not consumed.
    base = log_n;
    i_in_valid = 1'b1;
    i_in_data  = 8'h55;
    tick();
    tick();
    tick();
    check_eq("extra_no_ready", 32'(o_in_ready), 32'd0);
    i_in_valid = 1'b0;
    tick();
    check_eq("extra_no_write", 32'(log_n - base), 32'd0);
    check_eq("extra_done", 32'(o_done), 32'd1);
`else
    // Checksum match: 32 x 0x05 sums to 0xA0.
    base = log_n;
    begin_fill();
    for (int k = 0; k < 32; k++) push(8'h05);
    check_eq("ck_in_check_busy", 32'({o_busy, o_done}), 32'd2);
    push(8'hA0);
    tick();
    check_eq("ck_match_done", 32'(o_done), 32'd1);
    check_eq("ck_match_err", 32'(o_err), 32'd0);
    check_log("ck_match", base, 1'b1, 8'h05);

    // Checksum mismatch: 0xA1.
    base = log_n;
    begin_fill();
    for (int k = 0; k < 32; k++) push(8'h05);
    push(8'hA1);
    tick();
    check_eq("ck_bad_done", 32'(o_done), 32'd1);
    check_eq("ck_bad_err", 32'(o_err), 32'd1);
    tick();
    tick();
    check_eq("ck_bad_err_held", 32'(o_err), 32'd1);
    check_log("ck_bad", base, 1'b1, 8'h05);
    pulse_start();
    check_eq("ck_err_clear", 32'(o_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
